neuron_layer_sequencer: RTL and testbench

NEURON_LAYER_SEQUENCER -- requirements
Module: neuron_layer_sequencer

---
 rtl/neuron_layer_sequencer_if.sv | 36 +++
 rtl/neuron_layer_sequencer.sv | 135 +++++++++++++
 tb/tb_neuron_layer_sequencer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_layer_sequencer_if.sv
// Handshake and data bundle between a layer controller, the weight/bias ROM,
// a single neuron engine and the neuron_layer_sequencer that drives them.
interface neuron_layer_sequencer_if #(
   parameter int N_NEURONS = 4,
   parameter int ADDR_W    = 2
);
   logic                   start_layer;
   logic [63:0]            layer_inp;
   logic [ADDR_W-1:0]      w_addr;
   logic [63:0]            w_data;
   logic [7:0]             b_data;
   logic                   neuron_start;
   logic [63:0]            neuron_w;
   logic [63:0]            neuron_inp;
   logic [7:0]             neuron_bias;
   logic                   neuron_finish;
   logic [7:0]             neuron_out;
   logic [8*N_NEURONS-1:0] layer_out;
   logic                   layer_done;
   logic                   busy;
   logic                   timeout;

   // Environment side: controller, ROM and neuron engine
   modport master (
      output start_layer, layer_inp, w_data, b_data, neuron_finish, neuron_out,
      input  w_addr, neuron_start, neuron_w, neuron_inp, neuron_bias,
             layer_out, layer_done, busy, timeout
   );

   // Sequencer side
   modport slave (
      input  start_layer, layer_inp, w_data, b_data, neuron_finish, neuron_out,
      output w_addr, neuron_start, neuron_w, neuron_inp, neuron_bias,
             layer_out, layer_done, busy, timeout
   );
endinterface

// File: rtl/neuron_layer_sequencer.sv
// Runs one neural-network layer by time-multiplexing a single neuron engine:
// for each neuron index it fetches weights/bias from a synchronous ROM,
// starts the neuron, waits (with a watchdog) for its result and stores it in
// the corresponding layer_out slot.
module neuron_layer_sequencer #(
   parameter int N_NEURONS = 4,
   parameter int ADDR_W    = 2,
   parameter int TIMEOUT   = 255
) (
   input logic                     clk,
   input logic                     rst,
   neuron_layer_sequencer_if.slave bus
);

   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(N_NEURONS - 1);
   localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_START,
      S_WAIT,
      S_DONE
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [ADDR_W-1:0]      idx;
   logic [WD_W-1:0]        wd;
   logic                   idx_last;
   logic                   wd_expired;

   logic [63:0]            neuron_w_q;
   logic [63:0]            neuron_inp_q;
   logic [7:0]             neuron_bias_q;
   logic [8*N_NEURONS-1:0] layer_out_q;
   logic                   neuron_start_q;
   logic                   layer_done_q;
   logic                   busy_q;
   logic                   timeout_q;

   assign idx_last   = (idx == IDX_LAST);
   // wd counts finish-less WAIT cycles already spent; the current one is the last allowed
   assign wd_expired = (wd == WD_LAST);

   assign bus.w_addr       = idx;
   assign bus.neuron_w     = neuron_w_q;
   assign bus.neuron_inp   = neuron_inp_q;
   assign bus.neuron_bias  = neuron_bias_q;
   assign bus.layer_out    = layer_out_q;
   assign bus.neuron_start = neuron_start_q;
   assign bus.layer_done   = layer_done_q;
   assign bus.busy         = busy_q;
   assign bus.timeout      = timeout_q;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic: one pass FETCH-LOAD-START-WAIT per neuron, then DONE
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (bus.start_layer) state_nxt = S_FETCH;
         S_FETCH: state_nxt = S_LOAD;
         S_LOAD:  state_nxt = S_START;
         S_START: state_nxt = S_WAIT;
         S_WAIT: begin
            if (bus.neuron_finish) state_nxt = idx_last ? S_DONE : S_FETCH;
            else if (wd_expired)   state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath: index, watchdog, operand capture, result slots, error flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx           <= '0;
         wd            <= '0;
         neuron_w_q    <= '0;
         neuron_inp_q  <= '0;
         neuron_bias_q <= '0;
         layer_out_q   <= '0;
         timeout_q     <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (bus.start_layer) begin
                  neuron_inp_q <= bus.layer_inp;
                  idx          <= '0;
                  timeout_q    <= 1'b0;
               end
            end
            S_LOAD: begin
               neuron_w_q    <= bus.w_data;
               neuron_bias_q <= bus.b_data;
            end
            S_START: wd <= '0;
            S_WAIT: begin
               if (bus.neuron_finish) begin
                  for (int unsigned i = 0; i < N_NEURONS; i++) begin
                     if (idx == ADDR_W'(i)) layer_out_q[8*i +: 8] <= bus.neuron_out;
                  end
                  if (!idx_last) idx <= idx + 1'b1;
               end else if (wd_expired) begin
                  timeout_q <= 1'b1;
               end else begin
                  wd <= wd + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Status strobes are registered from the next state so they align with it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         neuron_start_q <= 1'b0;
         layer_done_q   <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         neuron_start_q <= (state_nxt == S_START);
         layer_done_q   <= (state_nxt == S_DONE);
         busy_q         <= (state_nxt != S_IDLE);
      end
   end

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Self-checking bench for neuron_layer_sequencer: a 4-neuron instance driven
// with randomized layers against a cycle-schedule model, plus a 1-neuron
// instance checked with hand-computed per-cycle expectations.
module tb_neuron_layer_sequencer;
   localparam int T = 8;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   chk = 0;
   int   err = 0;

   neuron_layer_sequencer_if #(.N_NEURONS(4), .ADDR_W(2)) if4 ();
   neuron_layer_sequencer_if #(.N_NEURONS(1), .ADDR_W(1)) if1 ();

   neuron_layer_sequencer #(.N_NEURONS(4), .ADDR_W(2), .TIMEOUT(T)) u_dut4 (
      .clk(clk), .rst(rst), .bus(if4));
   neuron_layer_sequencer #(.N_NEURONS(1), .ADDR_W(1), .TIMEOUT(T)) u_dut1 (
      .clk(clk), .rst(rst), .bus(if1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Neuron function used both by the stub engine and by the model
   function automatic logic [7:0] nres(input logic [63:0] w, input logic [7:0] b,
                                       input logic [63:0] x);
      logic [7:0] s;
      s = b + 8'h10;
      for (int j = 0; j < 8; j++) s = s + (w[8*j +: 8] ^ x[8*j +: 8]);
      return s;
   endfunction

   logic [63:0] rom_w [N];
   logic [7:0]  rom_b [N];

   // Synchronous ROMs and stub neurons
   always @(posedge clk) begin
      if4.w_data <= rom_w[if4.w_addr];
      if4.b_data <= rom_b[if4.w_addr];
   end
   always @(posedge clk) begin
      if1.w_data        <= '0;
      if1.b_data        <= 8'h05;
      if1.neuron_finish <= if1.neuron_start;
   end
   assign if4.neuron_out = nres(if4.neuron_w, if4.neuron_bias, if4.neuron_inp);
   assign if1.neuron_out = if1.neuron_bias + 8'h10;

   // Layer schedule model
   bit          chk_en;
   bit          lay_valid;
   int          lay_t0, lay_done, nst;
   int          st [N];
   int          fin [N];
   int          wend [N];
   logic [7:0]  res [N];
   logic [31:0] prev_lo, cur_lo;
   logic        prev_to, cur_to;
   logic [63:0] lay_inp;
   int          k_arr [N];
   int          obs_done, obs_starts;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s @cyc %0d: actual %0h required %0h", name, cyc, act, exp);
      end
   endtask

   function automatic bit is_fin(input int c);
      for (int i = 0; i < nst; i++) if (fin[i] == c) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit in_wait(input int c);
      for (int i = 0; i < nst; i++) if (c > st[i] && c <= wend[i]) return 1'b1;
      return 1'b0;
   endfunction

   // Cycle-by-cycle comparison against the schedule model
   always @(negedge clk) begin : cmp
      int          c;
      logic        e_busy, e_done, e_st, e_to;
      logic [31:0] e_lo;
      int          hi;
      if (chk_en) begin
         c      = cyc;
         e_busy = lay_valid && c > lay_t0 && c <= lay_done;
         e_done = lay_valid && c == lay_done;
         e_st   = 1'b0;
         e_lo   = lay_valid ? prev_lo : cur_lo;
         e_to   = !lay_valid ? cur_to : (c <= lay_t0 ? prev_to : (c < lay_done ? 1'b0 : cur_to));
         if (lay_valid) begin
            for (int i = 0; i < nst; i++) begin
               if (c == st[i]) e_st = 1'b1;
               if (fin[i] >= 0 && c > fin[i]) e_lo[8*i +: 8] = res[i];
               if (c >= st[i] - 2 && c <= wend[i]) check("w_addr", 64'(if4.w_addr), 64'(i));
               hi = (i + 1 < nst) ? st[i+1] - 1 : lay_done;
               if (c >= st[i] && c <= hi) begin
                  check("neuron_w", if4.neuron_w, rom_w[i]);
                  check("neuron_bias", 64'(if4.neuron_bias), 64'(rom_b[i]));
               end
            end
         end
         check("busy", 64'(if4.busy), 64'(e_busy));
         check("layer_done", 64'(if4.layer_done), 64'(e_done));
         check("neuron_start", 64'(if4.neuron_start), 64'(e_st));
         check("timeout", 64'(if4.timeout), 64'(e_to));
         check("layer_out", 64'(if4.layer_out), 64'(e_lo));
         if (e_busy) check("neuron_inp", if4.neuron_inp, lay_inp);
         if (if4.layer_done) obs_done = c;
         if (if4.neuron_start) obs_starts++;
      end
   end

   task automatic randomize_rom();
      for (int i = 0; i < N; i++) begin
         rom_w[i] = {$urandom, $urandom};
         rom_b[i] = 8'($urandom);
      end
   endtask

   // Runs one layer on the 4-neuron instance; called just after a clock edge
   task automatic run_layer(input bit hold, input bit noise, input bit spur,
                            input int rst_nrn, input bit zero_inp);
      int c, kk;
      logic [31:0] new_lo;
      logic to;
      prev_lo = cur_lo;
      prev_to = cur_to;
      lay_inp = zero_inp ? 64'h0 : {$urandom, $urandom};
      lay_t0  = cyc;
      c       = lay_t0 + 1;
      nst     = 0;
      to      = 1'b0;
      new_lo  = prev_lo;
      for (int i = 0; i < N; i++) begin
         st[i] = c + 2;
         nst   = i + 1;
         kk    = hold ? 1 : k_arr[i];
         if (kk <= T) begin
            fin[i]  = st[i] + kk;
            wend[i] = fin[i];
            res[i]  = nres(rom_w[i], rom_b[i], lay_inp);
            new_lo[8*i +: 8] = res[i];
            c = fin[i] + 1;
         end else begin
            fin[i]  = -1;
            wend[i] = st[i] + T;
            to      = 1'b1;
            c       = st[i] + T + 1;
            break;
         end
      end
      lay_done   = c;
      cur_lo     = new_lo;
      cur_to     = to;
      obs_done   = -1;
      obs_starts = 0;
      lay_valid  = 1'b1;
      if4.start_layer   = 1'b1;
      if4.layer_inp     = lay_inp;
      if4.neuron_finish = hold;
      while (cyc < lay_done + 2) begin
         @(posedge clk);
         #1;
         if (rst_nrn >= 0 && cyc == st[rst_nrn] + 2) begin
            rst       = 1'b0;
            chk_en    = 1'b0;
            lay_valid = 1'b0;
            cur_lo    = '0;
            cur_to    = 1'b0;
            if4.start_layer   = 1'b0;
            if4.neuron_finish = 1'b0;
            #1;
            check("rst_layer_out", 64'(if4.layer_out), 64'h0);
            check("rst_neuron_w", if4.neuron_w, 64'h0);
            check("rst_neuron_inp", if4.neuron_inp, 64'h0);
            check("rst_neuron_bias", 64'(if4.neuron_bias), 64'h0);
            check("rst_neuron_start", 64'(if4.neuron_start), 64'h0);
            check("rst_layer_done", 64'(if4.layer_done), 64'h0);
            check("rst_busy", 64'(if4.busy), 64'h0);
            check("rst_timeout", 64'(if4.timeout), 64'h0);
            check("rst_w_addr", 64'(if4.w_addr), 64'h0);
            @(negedge clk);
            #1;
            rst    = 1'b1;
            chk_en = 1'b1;
            return;
         end
         if4.start_layer   = spur && cyc < lay_done && ($urandom_range(0, 3) == 0);
         if4.layer_inp     = {$urandom, $urandom};
         if4.neuron_finish = hold || is_fin(cyc) ||
                             (noise && !in_wait(cyc) && ($urandom_range(0, 2) == 0));
      end
      if4.start_layer   = 1'b0;
      if4.neuron_finish = 1'b0;
   endtask

   // Single-neuron instance: hand-computed cycle expectations with k=1
   task automatic test_one();
      if1.start_layer = 1'b1;
      if1.layer_inp   = {$urandom, $urandom};
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk);
         #1;
         if1.start_layer = 1'b0;
         check("n1_busy", 64'(if1.busy), 64'(c <= 5));
         check("n1_neuron_start", 64'(if1.neuron_start), 64'(c == 3));
         check("n1_layer_done", 64'(if1.layer_done), 64'(c == 5));
      end
      check("n1_layer_out", 64'(if1.layer_out), 64'h15);
   endtask

   initial begin
      #400000;
      $display("FAIL sim_time_limit: actual expired required finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      chk_en = 1'b0; lay_valid = 1'b0;
      cur_lo = '0; cur_to = 1'b0; prev_lo = '0; prev_to = 1'b0;
      lay_t0 = 0; lay_done = 0; nst = 0; lay_inp = '0;
      obs_done = -1; obs_starts = 0;
      if4.start_layer = 1'b0; if4.layer_inp = '0; if4.neuron_finish = 1'b0;
      if1.start_layer = 1'b0; if1.layer_inp = '0;
      for (int i = 0; i < N; i++) begin
         rom_w[i] = '0; rom_b[i] = '0; k_arr[i] = 1;
      end
      repeat (2) @(posedge clk);
      #1;
      check("init_layer_out", 64'(if4.layer_out), 64'h0);
      check("init_busy", 64'(if4.busy), 64'h0);
      check("init_timeout", 64'(if4.timeout), 64'h0);
      check("init_neuron_inp", if4.neuron_inp, 64'h0);
      check("init_n1_busy", 64'(if1.busy), 64'h0);
      rst = 1'b1;
      chk_en = 1'b1;

      test_one();

      // Biases 1..4, zero weights and inputs: results are bias+0x10
      for (int i = 0; i < N; i++) begin
         rom_w[i] = '0; rom_b[i] = 8'(i + 1); k_arr[i] = 1;
      end
      run_layer(1'b0, 1'b0, 1'b0, -1, 1'b1);
      check("basic_layer_out", 64'(if4.layer_out), 64'h14131211);
      check("basic_done_latency", 64'(obs_done - lay_t0), 64'd17);
      check("basic_start_pulses", 64'(obs_starts), 64'd4);

      // First neuron never finishes: watchdog ends the layer
      k_arr[0] = 99;
      run_layer(1'b0, 1'b0, 1'b0, -1, 1'b0);
      check("to_flag", 64'(if4.timeout), 64'h1);
      check("to_slots_kept", 64'(if4.layer_out), 64'h14131211);
      check("to_done_latency", 64'(obs_done - lay_t0), 64'd12);
      check("to_start_pulses", 64'(obs_starts), 64'd1);

      // neuron_finish held high throughout
      randomize_rom();
      run_layer(1'b1, 1'b0, 1'b0, -1, 1'b0);
      check("hold_start_pulses", 64'(obs_starts), 64'd4);
      check("hold_timeout_cleared", 64'(if4.timeout), 64'h0);

      // Spurious start_layer and finish-at-watchdog-limit
      randomize_rom();
      k_arr[0] = 8; k_arr[1] = 1; k_arr[2] = 8; k_arr[3] = 3;
      run_layer(1'b0, 1'b1, 1'b1, -1, 1'b0);
      check("spur_done_latency", 64'(obs_done - lay_t0), 64'd33);
      check("spur_timeout", 64'(if4.timeout), 64'h0);

      // Reset during WAIT of neuron 2, then a fresh layer
      randomize_rom();
      k_arr[0] = 1; k_arr[1] = 2; k_arr[2] = 8; k_arr[3] = 1;
      run_layer(1'b0, 1'b0, 1'b0, 2, 1'b0);
      randomize_rom();
      k_arr[0] = 2; k_arr[1] = 3; k_arr[2] = 1; k_arr[3] = 4;
      run_layer(1'b0, 1'b0, 1'b0, -1, 1'b0);
      check("post_rst_done_latency", 64'(obs_done - lay_t0), 64'd23);
      check("post_rst_start_pulses", 64'(obs_starts), 64'd4);

      // Randomized layers, including occasional watchdog expiry
      repeat (20) begin
         randomize_rom();
         for (int i = 0; i < N; i++) k_arr[i] = $urandom_range(1, T + 1);
         run_layer(1'b0, 1'b1, 1'($urandom_range(0, 1)), -1, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", chk, err);
      $finish;
   end

endmodule
